// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared uop width, field layout and NOP encoding
package cpu_pkg;

  localparam int UOP_W = 20;

  typedef logic [UOP_W-1:0] uop_t;

  localparam uop_t UOP_NOP = 20'h0;

  // Field positions inside a uop; execute decodes these, the queue only carries them.
  localparam int ALU_HI     = 19;
  localparam int ALU_LO     = 16;
  localparam int MASK_BIT   = 15;
  localparam int LD_BIT     = 14;
  localparam int WR_BIT     = 13;
  localparam int FLAGS_BIT  = 12;
  localparam int DEST_HI    = 11;
  localparam int DEST_LO    = 8;
  localparam int ALU_MUX_HI = 7;
  localparam int ALU_MUX_LO = 6;
  localparam int B_HI       = 5;
  localparam int B_LO       = 3;
  localparam int A_HI       = 2;
  localparam int A_LO       = 0;

  function automatic logic [3:0] uop_dest(input uop_t u);
    return u[DEST_HI:DEST_LO];
  endfunction

endpackage

// File: rtl/uop_store.sv
// rtl/uop_store.sv - DEPTH x UOP_W register array, three write ports, one async read port
module uop_store
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [2:0]    we,
  input  logic [PW-1:0] waddr_0,
  input  logic [PW-1:0] waddr_1,
  input  logic [PW-1:0] waddr_2,
  input  logic [UOP_W-1:0] wdata_0,
  input  logic [UOP_W-1:0] wdata_1,
  input  logic [UOP_W-1:0] wdata_2,
  input  logic [PW-1:0] raddr,
  output logic [UOP_W-1:0] rdata
);

  logic [UOP_W-1:0] mem_q [DEPTH];
  logic [UOP_W-1:0] mem_d [DEPTH];

  // The three write addresses are consecutive mod DEPTH (DEPTH >= 4), so they never collide.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we[0]) mem_d[waddr_0] = wdata_0;
    if (we[1]) mem_d[waddr_1] = wdata_1;
    if (we[2]) mem_d[waddr_2] = wdata_2;
  end

  // Contents are deliberately not reset; occupancy masks stale entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uop_issue_queue.sv
// rtl/uop_issue_queue.sv - in-order uop buffer: 0..3 uops in per cycle, one issued per cycle
module uop_issue_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH),
  parameter int OW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [UOP_W-1:0] uop_0,
  input  logic [UOP_W-1:0] uop_1,
  input  logic [UOP_W-1:0] uop_2,
  input  logic [1:0]       uop_count,
  input  logic             flush,
  output logic             issue_valid,
  output logic [UOP_W-1:0] issue_uop,
  input  logic             issue_ack,
  output logic [OW-1:0]    occupancy
);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;

  logic          push, pop;
  logic [1:0]    n_in;
  logic [2:0]    we;
  logic [OW-1:0] free_slots;
  logic [UOP_W-1:0] head_uop;

  // Ready looks only at registered occupancy, so it never waits on this cycle's issue_ack.
  assign free_slots  = OW'(DEPTH) - occ_q;
  assign dec_ready   = free_slots >= OW'(3);
  assign issue_valid = occ_q != '0;
  assign issue_uop   = issue_valid ? head_uop : UOP_NOP;
  assign occupancy   = occ_q;

  assign push = dec_valid & dec_ready & ~flush;
  assign pop  = issue_valid & issue_ack & ~flush;
  assign n_in = push ? uop_count : 2'd0;
  assign we   = {n_in == 2'd3, n_in >= 2'd2, n_in >= 2'd1};

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(n_in);
      occ_d    = occ_q + OW'(n_in) - OW'(pop);
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  uop_store #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_store (
    .clk     (clk),
    .we      (we),
    .waddr_0 (wr_ptr_q),
    .waddr_1 (wr_ptr_q + PW'(1)),
    .waddr_2 (wr_ptr_q + PW'(2)),
    .wdata_0 (uop_0),
    .wdata_1 (uop_1),
    .wdata_2 (uop_2),
    .raddr   (rd_ptr_q),
    .rdata   (head_uop)
  );

endmodule
